geofence_src: RTL

Transmit-side driver for the geofence coordinate interface. It holds one round of 7 points in a local buffer: point 0 is the object, points 1..6 are the fence receivers. On start it streams the points on X/Y, one per cycle, then waits for the geofence valid/is_inside answer and latches the result. It sits between the host/control logic and the geofence core and owns round sequencing and timeout handling.

---
 rtl/geofence_src.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/geofence_src.sv
// geofence_src: transmit-side driver for the geofence coordinate interface.
//
// Holds one round of NUM_PTS points (point 0 = object, 1..6 = fence
// receivers). On start the points are streamed on X/Y one per cycle, then
// the block waits for the geofence valid/is_inside answer (bounded by
// TIMEOUT_CYC cycles) and latches the result.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   wr_en/wr_addr/    buffer write, honoured in IDLE only; wr_addr 7 ignored
//   wr_x/wr_y
//   start             begin a round (IDLE only)
//   X, Y, pt_vld,     point stream to the geofence core
//   pt_idx
//   valid, is_inside  geofence result strobe and value
//   busy              high in SEND and WAIT
//   done              one-cycle pulse at end of round
//   result, timeout   latched outcome of the last completed round
//
// Optional build macro GEOFENCE_SRC_STATS_EN adds clr_stats input and
// saturating round_cnt / inside_cnt outputs.

// One buffer entry: an X/Y pair with its own write strobe.
module geofence_src_pt #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q_o <= '0;
    else if (we_i) q_o <= d_i;
  end
endmodule

module geofence_src #(
  parameter int COORD_W     = 10,
  parameter int NUM_PTS     = 7,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               start,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  output logic               pt_vld,
  output logic [2:0]         pt_idx,
  input  logic               valid,
  input  logic               is_inside,
  output logic               busy,
  output logic               done,
  output logic               result,
  output logic               timeout
`ifdef GEOFENCE_SRC_STATS_EN
  ,
  input  logic               clr_stats,
  output logic [7:0]         round_cnt,
  output logic [7:0]         inside_cnt
`endif
);

  localparam int PW = 2 * COORD_W;
  localparam logic [2:0] LAST_IDX = 3'(NUM_PTS - 1);
  // Timer counts WAIT cycles already spent; the last allowed one is TIMEOUT_CYC-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] tmr_q, tmr_d;
  logic       result_q, result_d;
  logic       timeout_q, timeout_d;
  logic       busy_q, done_q;

  // ---------------- point buffer ----------------
  logic [NUM_PTS-1:0][PW-1:0] buf_q;

  for (genvar g = 0; g < NUM_PTS; g++) begin : g_pt
    logic we;
    // Writes land only in IDLE, so the buffer is frozen for the whole round.
    // A write sampled with start still lands before SEND reads it.
    assign we = (state_q == S_IDLE) && wr_en && (wr_addr == 3'(g));
    geofence_src_pt #(.W(PW)) u_pt (
      .clk   (clk),
      .reset (reset),
      .we_i  (we),
      .d_i   ({wr_x, wr_y}),
      .q_o   (buf_q[g])
    );
  end

  // ---------------- sequencing FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tmr_q     <= '0;
      result_q  <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d == S_SEND) || (state_d == S_WAIT);
      done_q    <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_d     = tmr_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEND;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_WAIT;
          idx_d   = '0;
          tmr_d   = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_WAIT: begin
        // valid takes priority over an expiring timer in the same cycle
        if (valid) begin
          result_d  = is_inside;
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end else if (tmr_q == TMO_LAST) begin
          result_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  // Stream outputs decode straight from registered state so point 0 shows
  // the cycle after start is sampled and drops to zero outside SEND.
  assign pt_vld  = (state_q == S_SEND);
  assign pt_idx  = pt_vld ? idx_q : 3'd0;
  assign X       = pt_vld ? buf_q[idx_q][PW-1:COORD_W] : '0;
  assign Y       = pt_vld ? buf_q[idx_q][COORD_W-1:0]  : '0;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign timeout = timeout_q;

`ifdef GEOFENCE_SRC_STATS_EN
  logic [7:0] round_cnt_q, inside_cnt_q;

  // Counters bump on the DONE cycle; result_q already holds the round outcome.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_cnt_q  <= '0;
      inside_cnt_q <= '0;
    end else if (clr_stats) begin
      round_cnt_q  <= '0;
      inside_cnt_q <= '0;
    end else if (state_q == S_DONE) begin
      if (round_cnt_q != 8'hFF)              round_cnt_q  <= round_cnt_q + 8'd1;
      if (result_q && inside_cnt_q != 8'hFF) inside_cnt_q <= inside_cnt_q + 8'd1;
    end
  end

  assign round_cnt  = round_cnt_q;
  assign inside_cnt = inside_cnt_q;
`endif

endmodule
